// File: rtl/alu_iqueue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_iqueue
//  Purpose  : Age-ordered ALU issue queue. Each entry holds two source
//             operands that wait for wake broadcasts. Every cycle the oldest
//             entry whose sources are both ready is issued. Younger entries
//             then shift down one slot, so slot 0 always holds the oldest.
//  Ports    : clk     - single clock, rising edge
//             reset   - synchronous, active-low reset
//             wen     - enqueue enable from the issue stage
//             stall   - downstream stall; suppresses issue when high
//             write   - enqueue request (valid + entry)
//             read    - issued entry; read.entry.valid=1 marks an issue
//             full    - occupancy equals QLEN (registered count only)
//             wake    - WAKE_N broadcasts of {valid, pid} becoming ready
//             retire  - flush; empties the queue at the next edge
//  Revision : 1.0 - initial release
// ============================================================================

package alu_iqueue_pkg;
    localparam int C_ID_W  = 5;
    localparam int C_PID_W = 6;
    localparam int C_DST_W = 6;
    localparam int C_CTL_W = 8;
    localparam int C_XLEN  = 32;

    typedef struct packed {
        logic               valid;
        logic [C_ID_W-1:0]  id;
        logic [C_PID_W-1:0] pid;
        logic               forward_en;
    } src_t;

    typedef struct packed {
        logic               valid;
        logic [C_DST_W-1:0] dst;
        src_t               src1;
        src_t               src2;
        logic [C_CTL_W-1:0] ctl;
        logic [C_XLEN-1:0]  imm;
        logic [C_XLEN-1:0]  pc;
    } iq_entry_t;

    typedef struct packed {
        logic      valid;
        iq_entry_t entry;
    } write_req_t;

    typedef struct packed {
        iq_entry_t entry;
    } read_resp_t;

    typedef struct packed {
        logic               valid;
        logic [C_PID_W-1:0] pid;
    } wake_t;
endpackage

module alu_iqueue
    import alu_iqueue_pkg::*;
#(
    parameter int QLEN   = 8,
    parameter int WAKE_N = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wen,
    input  logic                    stall,
    input  write_req_t              write,
    output read_resp_t              read,
    output logic                    full,
    input  wake_t [WAKE_N-1:0]      wake,
    input  logic                    retire
);

    localparam int C_IDX_W = $clog2(QLEN);
    localparam int C_CNT_W = C_IDX_W + 1;

    typedef wake_t [WAKE_N-1:0] wake_vec_t;

    // ------------------------------------------------------------------
    // Wake matching: a source becomes ready when it is waiting on a
    // forwarded value and any broadcast port carries its pid. Sources
    // with forward_en=0 already arrive valid and are left untouched.
    // ------------------------------------------------------------------
    function automatic src_t wake_src(input src_t s, input wake_vec_t w);
        src_t r;
        r = s;
        for (int k = 0; k < WAKE_N; k++) begin
            if (s.forward_en && w[k].valid && (w[k].pid == s.pid)) begin
                r.valid = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic iq_entry_t wake_entry(input iq_entry_t e, input wake_vec_t w);
        iq_entry_t r;
        r      = e;
        r.src1 = wake_src(e.src1, w);
        r.src2 = wake_src(e.src2, w);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    iq_entry_t              entries_q [QLEN];
    iq_entry_t              entries_d [QLEN];
    logic [C_CNT_W-1:0]     count_q;
    logic [C_CNT_W-1:0]     count_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    iq_entry_t              w_woken   [QLEN];
    iq_entry_t              w_shifted [QLEN];
    iq_entry_t              w_wr_entry;
    logic [QLEN-1:0]        w_ready;
    logic                   w_any_ready;
    logic                   w_issue;
    logic                   w_wr_ok;
    logic [C_IDX_W-1:0]     w_sel;
    logic [C_CNT_W-1:0]     w_wr_pos;

    // Per-slot readiness and the post-wake copy of each stored entry.
    // Readiness uses the registered sources, so a wake seen this cycle
    // only makes the entry issuable from the next cycle on.
    for (genvar g = 0; g < QLEN; g++) begin : g_slot
        assign w_ready[g] = entries_q[g].valid
                          & entries_q[g].src1.valid
                          & entries_q[g].src2.valid;
        assign w_woken[g] = wake_entry(entries_q[g], wake);
    end

    // Oldest-first selection: scanning from the youngest slot down means
    // the last hit recorded is the lowest (oldest) ready slot.
    always_comb begin
        w_any_ready = 1'b0;
        w_sel       = '0;
        for (int i = QLEN - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_any_ready = 1'b1;
                w_sel       = C_IDX_W'(i);
            end
        end
    end

    // Reset gating keeps the output quiet while reset is held, even on
    // the very first cycle before the clearing edge has been taken.
    assign w_issue = w_any_ready & ~stall & reset;

    // Full is taken from the registered count only; a same-cycle issue
    // does not open a slot for a write.
    assign full    = (count_q == C_CNT_W'(QLEN));
    assign w_wr_ok = wen & write.valid & ~full;

    // The new entry lands right after the youngest entry as it will look
    // after compaction, hence one slot lower when an issue happens too.
    assign w_wr_pos = w_issue ? (count_q - C_CNT_W'(1)) : count_q;

    // Incoming entries see the same wake broadcast before being stored.
    always_comb begin
        w_wr_entry       = wake_entry(write.entry, wake);
        w_wr_entry.valid = 1'b1;
    end

    // Issue output
    always_comb begin
        read = '0;
        if (w_issue) begin
            read.entry = entries_q[w_sel];
        end
    end

    // ------------------------------------------------------------------
    // Next state: compaction, enqueue, flush
    // ------------------------------------------------------------------
    always_comb begin
        // Slots at or above the issued one take their younger neighbour.
        // The top slot has no neighbour; QLEN is a power of two so the
        // modulo only keeps the index in range for that unused path.
        for (int i = 0; i < QLEN; i++) begin
            if (w_issue && (C_IDX_W'(i) >= w_sel)) begin
                if (i < QLEN - 1) begin
                    w_shifted[i] = w_woken[(i + 1) % QLEN];
                end else begin
                    w_shifted[i] = '0;
                end
            end else begin
                w_shifted[i] = w_woken[i];
            end
        end

        for (int i = 0; i < QLEN; i++) begin
            entries_d[i] = w_shifted[i];
            if (w_wr_ok && (C_CNT_W'(i) == w_wr_pos)) begin
                entries_d[i] = w_wr_entry;
            end
        end

        count_d = count_q + C_CNT_W'(w_wr_ok) - C_CNT_W'(w_issue);

        // Flush overrides any enqueue or dequeue in the same cycle.
        if (retire) begin
            for (int i = 0; i < QLEN; i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < QLEN; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_iqueue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_iqueue
//  Purpose  : Self-checking bench for alu_iqueue. A queue-based reference
//             model tracks the expected contents; directed scenarios and
//             randomized traffic compare read/full against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iqueue;
    import alu_iqueue_pkg::*;

    localparam int QLEN   = 8;
    localparam int WAKE_N = 4;

    logic                clk;
    logic                reset;
    logic                wen;
    logic                stall;
    write_req_t          write;
    read_resp_t          read;
    logic                full;
    wake_t [WAKE_N-1:0]  wake;
    logic                retire;

    int vec  = 0;
    int miss = 0;

    iq_entry_t mq[$];

    alu_iqueue #(.QLEN(QLEN), .WAKE_N(WAKE_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .wen    (wen),
        .stall  (stall),
        .write  (write),
        .read   (read),
        .full   (full),
        .wake   (wake),
        .retire (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a plain queue, oldest at index 0
    // ------------------------------------------------------------------
    function automatic iq_entry_t tb_wake(input iq_entry_t e);
        iq_entry_t r;
        r = e;
        for (int k = 0; k < WAKE_N; k++) begin
            if (wake[k].valid) begin
                if (e.src1.forward_en && (e.src1.pid == wake[k].pid)) r.src1.valid = 1'b1;
                if (e.src2.forward_en && (e.src2.pid == wake[k].pid)) r.src2.valid = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic iq_entry_t model_read();
        iq_entry_t r;
        int        hit[$];
        r = '0;
        if (reset && !stall) begin
            hit = mq.find_first_index with (item.src1.valid && item.src2.valid);
            if (hit.size() > 0) r = mq[hit[0]];
        end
        return r;
    endfunction

    function automatic void model_step();
        int        hit[$];
        int        n;
        iq_entry_t e;
        if (!reset || retire) begin
            mq.delete();
            return;
        end
        n   = mq.size();
        hit = mq.find_first_index with (item.src1.valid && item.src2.valid);
        foreach (mq[i]) mq[i] = tb_wake(mq[i]);
        if (!stall && hit.size() > 0) mq.delete(hit[0]);
        if (wen && write.valid && n < QLEN) begin
            e       = tb_wake(write.entry);
            e.valid = 1'b1;
            mq.push_back(e);
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen    = 1'b0;
        stall  = 1'b0;
        write  = '0;
        wake   = '0;
        retire = 1'b0;
    endtask

    function automatic iq_entry_t mk(input logic [31:0] pc, input logic [C_DST_W-1:0] dst,
                                     input logic s1_rdy, input logic [C_PID_W-1:0] p1,
                                     input logic s2_rdy, input logic [C_PID_W-1:0] p2);
        iq_entry_t e;
        e                 = '0;
        e.valid           = 1'b1;
        e.dst             = dst;
        e.pc              = pc;
        e.imm             = $urandom;
        e.ctl             = C_CTL_W'($urandom);
        e.src1.valid      = s1_rdy;
        e.src1.forward_en = ~s1_rdy;
        e.src1.pid        = p1;
        e.src1.id         = C_ID_W'($urandom);
        e.src2.valid      = s2_rdy;
        e.src2.forward_en = ~s2_rdy;
        e.src2.pid        = p2;
        e.src2.id         = C_ID_W'($urandom);
        return e;
    endfunction

    function automatic iq_entry_t rand_entry();
        iq_entry_t e;
        e                 = '0;
        e.valid           = 1'b1;
        e.dst             = C_DST_W'($urandom);
        e.ctl             = C_CTL_W'($urandom);
        e.imm             = $urandom;
        e.pc              = $urandom;
        e.src1.id         = C_ID_W'($urandom);
        e.src1.pid        = C_PID_W'($urandom_range(15, 0));
        e.src1.valid      = 1'($urandom_range(1, 0));
        e.src1.forward_en = e.src1.valid ? 1'($urandom_range(1, 0)) : 1'b1;
        e.src2.id         = C_ID_W'($urandom);
        e.src2.pid        = C_PID_W'($urandom_range(15, 0));
        e.src2.valid      = 1'($urandom_range(1, 0));
        e.src2.forward_en = e.src2.valid ? 1'($urandom_range(1, 0)) : 1'b1;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        idle();
        wen         = 1'b1;
        write.valid = 1'b1;
        write.entry = mk(32'h0000_4000, 6'd1, 1'b1, 6'd0, 1'b1, 6'd0);
        repeat (2) begin
            @(negedge clk);
            if (read !== '0) begin miss++; $display("FAIL reset_read got=%h want=0", read); end
            vec++;
            if (full !== 1'b0) begin miss++; $display("FAIL reset_full got=%b want=0", full); end
            vec++;
            tick();
        end
        reset = 1'b1;
        idle();
        @(negedge clk);
        if (read !== '0) begin miss++; $display("FAIL reset_after_read got=%h want=0", read); end
        vec++;
        if (full !== 1'b0) begin miss++; $display("FAIL reset_after_full got=%b want=0", full); end
        vec++;
        tick();
    endtask

    task automatic test_single();
        idle();
        wen         = 1'b1;
        write.valid = 1'b1;
        write.entry = mk(32'h8000_0000, 6'd5, 1'b1, 6'd0, 1'b1, 6'd0);
        @(negedge clk);
        if (read.entry.valid !== 1'b0) begin miss++; $display("FAIL single_same_cycle valid got=%b want=0", read.entry.valid); end
        vec++;
        tick();
        idle();
        @(negedge clk);
        if (read.entry.valid !== 1'b1 || read.entry.pc !== 32'h8000_0000 || read.entry.dst !== 6'd5) begin
            miss++;
            $display("FAIL single_issue got v=%b pc=%h dst=%0d want v=1 pc=80000000 dst=5", read.entry.valid, read.entry.pc, read.entry.dst);
        end
        vec++;
        tick();
        @(negedge clk);
        if (read.entry.valid !== 1'b0) begin miss++; $display("FAIL single_drained valid got=%b want=0", read.entry.valid); end
        vec++;
        tick();
    endtask

    task automatic test_fill();
        idle();
        for (int i = 0; i < QLEN; i++) begin
            wen         = 1'b1;
            write.valid = 1'b1;
            write.entry = mk(32'h1000 + i, C_DST_W'(i), 1'b0, C_PID_W'(20 + i), 1'b1, 6'd0);
            @(negedge clk);
            if (full !== 1'b0) begin miss++; $display("FAIL fill_not_full slot=%0d got=%b want=0", i, full); end
            vec++;
            tick();
        end
        // 9th write is offered while full
        write.entry = mk(32'h1008, 6'd8, 1'b0, 6'd28, 1'b1, 6'd0);
        @(negedge clk);
        if (full !== 1'b1) begin miss++; $display("FAIL fill_full got=%b want=1", full); end
        vec++;
        tick();
        idle();
        wake[0] = '{valid: 1'b1, pid: 6'd23};
        @(negedge clk);
        if (full !== 1'b1 || read.entry.valid !== 1'b0) begin
            miss++; $display("FAIL fill_hold got full=%b v=%b want full=1 v=0", full, read.entry.valid);
        end
        vec++;
        tick();
        // Issue while full; a write offered now must still be dropped
        idle();
        wen         = 1'b1;
        write.valid = 1'b1;
        write.entry = mk(32'h1009, 6'd9, 1'b0, 6'd29, 1'b1, 6'd0);
        @(negedge clk);
        if (read.entry.valid !== 1'b1 || read.entry.pc !== 32'h1003 || full !== 1'b1) begin
            miss++; $display("FAIL fill_wake_issue got v=%b pc=%h full=%b want v=1 pc=1003 full=1", read.entry.valid, read.entry.pc, full);
        end
        vec++;
        tick();
        idle();
        wake[0] = '{valid: 1'b1, pid: 6'd28};
        wake[1] = '{valid: 1'b1, pid: 6'd29};
        @(negedge clk);
        if (full !== 1'b0 || read.entry.valid !== 1'b0) begin
            miss++; $display("FAIL fill_after_remove got full=%b v=%b want full=0 v=0", full, read.entry.valid);
        end
        vec++;
        tick();
        idle();
        @(negedge clk);
        if (read.entry.valid !== 1'b0) begin
            miss++; $display("FAIL fill_dropped_writes got v=%b pc=%h want v=0", read.entry.valid, read.entry.pc);
        end
        vec++;
        retire = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_age();
        idle();
        wen         = 1'b1;
        write.valid = 1'b1;
        write.entry = mk(32'hA000_0000, 6'd10, 1'b0, 6'd12, 1'b1, 6'd0);
        tick();
        write.entry = mk(32'hB000_0000, 6'd11, 1'b1, 6'd0, 1'b1, 6'd0);
        @(negedge clk);
        if (read.entry.valid !== 1'b0) begin miss++; $display("FAIL age_none_ready got v=%b want 0", read.entry.valid); end
        vec++;
        tick();
        idle();
        wake[1] = '{valid: 1'b1, pid: 6'd12};
        @(negedge clk);
        if (read.entry.valid !== 1'b1 || read.entry.pc !== 32'hB000_0000) begin
            miss++; $display("FAIL age_b_first got v=%b pc=%h want v=1 pc=b0000000", read.entry.valid, read.entry.pc);
        end
        vec++;
        tick();
        idle();
        @(negedge clk);
        if (read.entry.valid !== 1'b1 || read.entry.pc !== 32'hA000_0000) begin
            miss++; $display("FAIL age_a_after_wake got v=%b pc=%h want v=1 pc=a0000000", read.entry.valid, read.entry.pc);
        end
        vec++;
        tick();
        @(negedge clk);
        if (read.entry.valid !== 1'b0) begin miss++; $display("FAIL age_drained got v=%b want 0", read.entry.valid); end
        vec++;
        tick();
    endtask

    task automatic test_stall();
        idle();
        wen         = 1'b1;
        write.valid = 1'b1;
        write.entry = mk(32'hC000_0000, 6'd3, 1'b1, 6'd0, 1'b1, 6'd0);
        tick();
        idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (read !== '0 || full !== 1'b0) begin
                miss++; $display("FAIL stall_hold cyc=%0d got v=%b full=%b want v=0 full=0", i, read.entry.valid, full);
            end
            vec++;
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        if (read.entry.valid !== 1'b1 || read.entry.pc !== 32'hC000_0000) begin
            miss++; $display("FAIL stall_release got v=%b pc=%h want v=1 pc=c0000000", read.entry.valid, read.entry.pc);
        end
        vec++;
        tick();
    endtask

    task automatic test_wake_on_write();
        idle();
        wen         = 1'b1;
        write.valid = 1'b1;
        write.entry = mk(32'hD000_0000, 6'd7, 1'b1, 6'd0, 1'b0, 6'd7);
        wake[0]     = '{valid: 1'b1, pid: 6'd7};
        @(negedge clk);
        if (read.entry.valid !== 1'b0) begin miss++; $display("FAIL wow_same_cycle got v=%b want 0", read.entry.valid); end
        vec++;
        tick();
        idle();
        @(negedge clk);
        if (read.entry.valid !== 1'b1 || read.entry.pc !== 32'hD000_0000 || read.entry.src2.valid !== 1'b1) begin
            miss++; $display("FAIL wow_issue got v=%b pc=%h s2v=%b want v=1 pc=d0000000 s2v=1", read.entry.valid, read.entry.pc, read.entry.src2.valid);
        end
        vec++;
        tick();
    endtask

    // use_reset=0 flushes with retire, 1 with a mid-operation reset pulse
    task automatic test_flush(input bit use_reset);
        idle();
        for (int i = 0; i < 4; i++) begin
            wen         = 1'b1;
            write.valid = 1'b1;
            write.entry = mk(32'h2000 + i, C_DST_W'(i), 1'b0, C_PID_W'(40 + i), 1'b1, 6'd0);
            tick();
        end
        idle();
        if (use_reset) reset = 1'b0;
        else           retire = 1'b1;
        tick();
        idle();
        reset = 1'b1;
        for (int k = 0; k < WAKE_N; k++) wake[k] = '{valid: 1'b1, pid: C_PID_W'(40 + k)};
        @(negedge clk);
        if (read !== '0 || full !== 1'b0) begin
            miss++; $display("FAIL flush_%0d_after got v=%b full=%b want v=0 full=0", use_reset, read.entry.valid, full);
        end
        vec++;
        tick();
        idle();
        @(negedge clk);
        if (read.entry.valid !== 1'b0) begin
            miss++; $display("FAIL flush_%0d_empty got v=%b pc=%h want v=0", use_reset, read.entry.valid, read.entry.pc);
        end
        vec++;
        tick();
    endtask

    task automatic test_random_traffic(input int cycles);
        iq_entry_t exp;
        logic      exp_full;
        idle();
        for (int c = 0; c < cycles; c++) begin
            wen         = ($urandom_range(3, 0) != 0);
            write.valid = ($urandom_range(7, 0) != 0);
            write.entry = rand_entry();
            stall       = ($urandom_range(4, 0) == 0);
            retire      = ($urandom_range(80, 0) == 0);
            reset       = ($urandom_range(150, 0) != 0);
            for (int k = 0; k < WAKE_N; k++) begin
                wake[k].valid = ($urandom_range(3, 0) == 0);
                wake[k].pid   = C_PID_W'($urandom_range(15, 0));
            end
            @(negedge clk);
            exp      = model_read();
            exp_full = (mq.size() == QLEN);
            if (read.entry !== exp) begin
                miss++; $display("FAIL rand_read cyc=%0d got=%h want=%h", c, read.entry, exp);
            end
            vec++;
            if (full !== exp_full) begin
                miss++; $display("FAIL rand_full cyc=%0d got=%b want=%b", c, full, exp_full);
            end
            vec++;
            tick();
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_single();
        test_fill();
        test_age();
        test_stall();
        test_wake_on_write();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random_traffic(1500);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_iqueue.md
ALU_IQUEUE -- requirements
Module: alu_iqueue

Interface
REQ-001 SHALL have parameter QLEN, default 8: number of queue entries, power of two, minimum 2.
REQ-002 SHALL have parameter WAKE_N, default 4: number of wake broadcast ports.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port wen, input, 1 bit: global enqueue enable from the issue stage.
REQ-006 SHALL have port stall, input, 1 bit: downstream stall; when 1, no entry is issued.
REQ-007 SHALL have port write, input, write_req_t: valid plus an iq_entry_t.
- iq_entry_t fields: valid, dst, src1/src2 {valid, id, pid, forward_en}, ctl, imm, pc.
REQ-008 SHALL have port read, output, read_resp_t: the issued iq_entry_t; entry.valid=1 marks an issue this cycle.
REQ-009 SHALL have port full, output, 1 bit: 1 when occupancy equals QLEN.
REQ-010 SHALL have port wake, input, WAKE_N x {valid, pid}: physical registers becoming ready this cycle.
REQ-011 SHALL have port retire, input, 1 bit: flush.

Function
REQ-012 SHALL hold up to QLEN entries in age order (slot 0 oldest), with a count register of width $clog2(QLEN)+1.
REQ-013 SHALL enqueue write.entry into the slot after the youngest entry on a clock edge when wen=1, write.valid=1 and full=0; any other write is dropped.
REQ-014 SHALL compute full from the registered count only (count==QLEN), so a dequeue in the same cycle does not permit a write while full=1.
REQ-015 SHALL treat an entry as ready when src1.valid=1 and src2.valid=1.
REQ-016 SHALL, each cycle, combinationally select the oldest ready entry and drive it on read.entry with valid=1.
REQ-017 SHALL drive read as all zeros when no entry is ready or when stall=1.
REQ-018 SHALL remove the issued entry at the clock edge when an entry issues and stall=0, shifting younger entries down one slot to preserve age order.
REQ-019 SHALL handle a simultaneous enqueue and dequeue in one cycle: count is unchanged and the new entry lands after the compacted youngest entry.
REQ-020 SHALL set srcN.valid of a stored entry at the clock edge when srcN.forward_en=1, wake[k].valid=1 and wake[k].pid==srcN.pid, for any k; the entry becomes issuable the next cycle.
REQ-021 SHALL apply the same wake match to an entry being enqueued in the same cycle before storing it.
REQ-022 SHALL never issue an entry in the cycle it is written (minimum enqueue-to-issue latency is 1 cycle).
REQ-023 SHALL ignore sources with forward_en=0; such sources arrive with valid=1.
REQ-024 SHALL, when retire=1, clear all entries and set count=0 at the clock edge, overriding any enqueue or dequeue in that cycle.
REQ-025 SHALL never overflow or underflow: count stays within 0..QLEN.

Reset
REQ-026 SHALL, when reset=0 at a rising edge, clear every entry valid bit and set count=0.
REQ-027 SHALL, while and after reset with no writes, drive full=0 and read all zeros.
REQ-028 SHALL, when reset is asserted mid-operation, discard all pending entries with no issue in the following cycle.

Verification
REQ-029 Single ready entry: write one entry with srcs valid (pc=0x80000000, dst=5), wen=1 -> next cycle read.entry.valid=1, pc=0x80000000, dst=5; the cycle after, read.valid=0.
REQ-030 Fill: 8 back-to-back writes of non-ready entries -> full=1 after the 8th edge; a 9th write is dropped; after wake of one entry it issues and full=0 the cycle after its removal.
REQ-031 Age order: entries A (not ready, src1.pid=12) then B (ready) -> B issues first; wake pid=12 -> A issues the next cycle.
REQ-032 Stall: hold stall=1 for 3 cycles with a ready entry -> read.valid=0 throughout and count unchanged; release -> the entry issues.
REQ-033 Wake on write: write an entry with src2.pid=7 not ready while wake[0]={1,7} -> the entry issues the next cycle.
REQ-034 Flush/reset: 4 stored entries, retire=1 (or reset=0) -> count=0, read.valid=0 and full=0 the following cycle.
